// File: rtl/eqed_err_detector_if.sv
// Stream, injection and result bundle between the EQED harness and its divergence detector.
// master = harness side (drives streams/injection), slave = detector side.
interface eqed_err_detector_if #(
  parameter int DW    = 3,
  parameter int SIG_W = 6,
  parameter int SEL_W = 4,
  parameter int LAT_W = 5
);
  logic             start;
  logic [DW-1:0]    gold_out;
  logic [DW-1:0]    dut_out;
  logic             inj_valid;
  logic [SEL_W-1:0] inj_sel;
  logic             busy;
  logic             result_valid;
  logic             detected;
  logic             masked;
  logic             spurious;
  logic [LAT_W-1:0] det_latency;
  logic [SEL_W-1:0] det_sel;
  logic [SIG_W-1:0] gold_sig;
  logic [SIG_W-1:0] dut_sig;

  modport master (
    output start, gold_out, dut_out, inj_valid, inj_sel,
    input  busy, result_valid, detected, masked, spurious,
           det_latency, det_sel, gold_sig, dut_sig
  );

  modport slave (
    input  start, gold_out, dut_out, inj_valid, inj_sel,
    output busy, result_valid, detected, masked, spurious,
           det_latency, det_sel, gold_sig, dut_sig
  );
endinterface

// File: rtl/eqed_err_detector.sv
// EQED detection end: compacts golden and faulty streams into MISRs and classifies a one-shot
// single-bit-flip run as detected, masked or spurious, with latency and captured injection site.
module eqed_err_detector #(
  parameter int               DW       = 3,
  parameter int               SIG_W    = 6,
  parameter logic [SIG_W-1:0] SEED     = SIG_W'(6'h01),
  parameter logic [SIG_W-1:0] TAP_MASK = SIG_W'(6'b110000),
  parameter int               SEL_W    = 4,
  parameter int               WINDOW   = 16,
  parameter int               LAT_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  eqed_err_detector_if.slave  io_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WATCH,
    S_REPORT
  } state_t;

  state_t           r_state, w_state_next;
  logic [SIG_W-1:0] r_gold_sig, w_gold_sig_next;
  logic [SIG_W-1:0] r_dut_sig, w_dut_sig_next;
  logic [LAT_W-1:0] r_cnt, w_cnt_next;
  logic             r_detected, w_detected_next;
  logic             r_masked, w_masked_next;
  logic             r_spurious, w_spurious_next;
  logic [LAT_W-1:0] r_det_latency, w_det_latency_next;
  logic [SEL_W-1:0] r_det_sel, w_det_sel_next;

  logic [SIG_W-1:0] w_gold_misr;
  logic [SIG_W-1:0] w_dut_misr;
  logic             w_sig_mismatch;

  // Stream bit j folds into even stage 2j so every input bit enters a distinct stage.
  assign w_gold_misr[0] = ^(r_gold_sig & TAP_MASK) ^ io_bus.gold_out[0];
  assign w_dut_misr[0]  = ^(r_dut_sig & TAP_MASK) ^ io_bus.dut_out[0];

  for (genvar gi = 1; gi < SIG_W; gi++) begin : g_misr
    if ((gi % 2 == 0) && (gi / 2 < DW)) begin : g_fold
      assign w_gold_misr[gi] = r_gold_sig[gi-1] ^ io_bus.gold_out[gi/2];
      assign w_dut_misr[gi]  = r_dut_sig[gi-1] ^ io_bus.dut_out[gi/2];
    end else begin : g_shift
      assign w_gold_misr[gi] = r_gold_sig[gi-1];
      assign w_dut_misr[gi]  = r_dut_sig[gi-1];
    end
  end

  assign w_sig_mismatch = (r_gold_sig != r_dut_sig);

  always_comb begin
    w_state_next       = r_state;
    w_gold_sig_next    = r_gold_sig;
    w_dut_sig_next     = r_dut_sig;
    w_cnt_next         = r_cnt;
    w_detected_next    = r_detected;
    w_masked_next      = r_masked;
    w_spurious_next    = r_spurious;
    w_det_latency_next = r_det_latency;
    w_det_sel_next     = r_det_sel;

    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_state_next       = S_ARMED;
          w_gold_sig_next    = SEED;
          w_dut_sig_next     = SEED;
          w_cnt_next         = '0;
          w_detected_next    = 1'b0;
          w_masked_next      = 1'b0;
          w_spurious_next    = 1'b0;
          w_det_latency_next = '0;
          w_det_sel_next     = '0;
        end
      end

      S_ARMED: begin
        w_gold_sig_next = w_gold_misr;
        w_dut_sig_next  = w_dut_misr;
        // A divergence before any injection means the pair was never equivalent.
        if (w_sig_mismatch) begin
          w_spurious_next = 1'b1;
          w_state_next    = S_REPORT;
        end else if (io_bus.inj_valid) begin
          w_det_sel_next = io_bus.inj_sel;
          w_cnt_next     = LAT_W'(1);
          w_state_next   = S_WATCH;
        end
      end

      S_WATCH: begin
        w_gold_sig_next = w_gold_misr;
        w_dut_sig_next  = w_dut_misr;
        if (w_sig_mismatch) begin
          w_detected_next    = 1'b1;
          w_det_latency_next = r_cnt;
          w_state_next       = S_REPORT;
        end else if (r_cnt == LAT_W'(WINDOW)) begin
          w_masked_next = 1'b1;
          w_state_next  = S_REPORT;
        end else begin
          w_cnt_next = r_cnt + LAT_W'(1);
        end
      end

      S_REPORT: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_gold_sig    <= '0;
      r_dut_sig     <= '0;
      r_cnt         <= '0;
      r_detected    <= 1'b0;
      r_masked      <= 1'b0;
      r_spurious    <= 1'b0;
      r_det_latency <= '0;
      r_det_sel     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_gold_sig    <= w_gold_sig_next;
      r_dut_sig     <= w_dut_sig_next;
      r_cnt         <= w_cnt_next;
      r_detected    <= w_detected_next;
      r_masked      <= w_masked_next;
      r_spurious    <= w_spurious_next;
      r_det_latency <= w_det_latency_next;
      r_det_sel     <= w_det_sel_next;
    end
  end

  assign io_bus.busy         = (r_state != S_IDLE);
  assign io_bus.result_valid = (r_state == S_REPORT);
  assign io_bus.detected     = r_detected;
  assign io_bus.masked       = r_masked;
  assign io_bus.spurious     = r_spurious;
  assign io_bus.det_latency  = r_det_latency;
  assign io_bus.det_sel      = r_det_sel;
  assign io_bus.gold_sig     = r_gold_sig;
  assign io_bus.dut_sig      = r_dut_sig;

endmodule

// File: tb/tb_eqed_err_detector.sv
// Scenario bench for eqed_err_detector: expected run results are queued when the injection is
// driven and popped when result_valid appears.
module tb_eqed_err_detector;
  localparam int DW     = 3;
  localparam int SIG_W  = 6;
  localparam int SEL_W  = 4;
  localparam int WINDOW = 16;
  localparam int LAT_W  = 5;

  logic clk;
  logic rst;

  eqed_err_detector_if #(.DW(DW), .SIG_W(SIG_W), .SEL_W(SEL_W), .LAT_W(LAT_W)) bus ();

  eqed_err_detector #(
    .DW(DW), .SIG_W(SIG_W), .SEED(6'h01), .TAP_MASK(6'b110000),
    .SEL_W(SEL_W), .WINDOW(WINDOW), .LAT_W(LAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  typedef struct packed {
    logic       det;
    logic       msk;
    logic       spu;
    logic [4:0] lat;
    logic [3:0] sel;
  } res_t;

  typedef struct {
    string name;
    res_t  r;
    int    cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] misr_model(input logic [5:0] s, input logic [2:0] d);
    logic [5:0] n;
    n[0] = ^(s & 6'b110000) ^ d[0];
    n[1] = s[0];
    n[2] = s[1] ^ d[1];
    n[3] = s[2];
    n[4] = s[3] ^ d[2];
    n[5] = s[4];
    return n;
  endfunction

  function automatic res_t sample_res();
    res_t r;
    r.det = bus.detected;
    r.msk = bus.masked;
    r.spu = bus.spurious;
    r.lat = bus.det_latency;
    r.sel = bus.det_sel;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_eq(input logic [2:0] v);
    bus.gold_out = v;
    bus.dut_out  = v;
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Injection at ARMED cycle pre+1 (cycle T); one-cycle difference 'diff' on dut_out at T+d_off.
  task automatic run_detect(input string name, input int pre, input int d_off,
                            input logic [2:0] diff, input logic [3:0] sel,
                            output int n, output bit seen);
    exp_t       e;
    logic [2:0] v;
    start_run();
    for (int i = 0; i < pre; i++) begin
      drive_eq(3'($urandom_range(0, 7)));
      step();
    end
    drive_eq(3'($urandom_range(0, 7)));
    bus.inj_valid = 1'b1;
    bus.inj_sel   = sel;
    e.name  = name;
    e.r     = '0;
    e.r.sel = sel;
    if (diff != 3'b000 && d_off + 1 <= WINDOW) begin
      e.r.det = 1'b1;
      e.r.lat = 5'(d_off + 1);
      e.cyc   = d_off + 2;
    end else begin
      e.r.msk = 1'b1;
      e.cyc   = WINDOW + 1;
    end
    sb_q.push_back(e);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * WINDOW) begin
      step();
      n++;
      bus.inj_valid = 1'b0;
      bus.inj_sel   = 4'($urandom_range(0, 15));
      v = 3'($urandom_range(0, 7));
      bus.gold_out = v;
      bus.dut_out  = (n == d_off) ? (v ^ diff) : v;
      seen = bus.result_valid;
    end
    drive_eq(3'b000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_checks++; if (bus.result_valid !== 1'b0) begin n_errors++; $display("FAIL reset_result_valid: got %b required 0", bus.result_valid); end
    n_checks++; if ({bus.detected, bus.masked, bus.spurious} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b required 000", {bus.detected, bus.masked, bus.spurious}); end
    n_checks++; if (bus.det_latency !== 5'd0 || bus.det_sel !== 4'd0) begin n_errors++; $display("FAIL reset_lat_sel: got lat=%0d sel=%0d required 0/0", bus.det_latency, bus.det_sel); end
    n_checks++; if (bus.gold_sig !== 6'd0 || bus.dut_sig !== 6'd0) begin n_errors++; $display("FAIL reset_sigs: got %h/%h required 00/00", bus.gold_sig, bus.dut_sig); end
    rst = 1'b0;
    step();
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_hold: busy got %b required 0", bus.busy); end
    $display("txn reset: busy=%b sigs=%h/%h", bus.busy, bus.gold_sig, bus.dut_sig);
  endtask

  task automatic test_misr();
    logic [5:0] m;
    logic [2:0] v;
    start_run();
    n_checks++; if (bus.busy !== 1'b1 || bus.gold_sig !== 6'h01 || bus.dut_sig !== 6'h01) begin n_errors++; $display("FAIL misr_seed: got busy=%b sigs=%h/%h required 1 01/01", bus.busy, bus.gold_sig, bus.dut_sig); end
    drive_eq(3'b001);
    step();
    n_checks++; if (bus.gold_sig !== 6'b000011) begin n_errors++; $display("FAIL misr_first: got %b required 000011", bus.gold_sig); end
    m = 6'b000011;
    for (int i = 0; i < 8; i++) begin
      v = 3'($urandom_range(0, 7));
      drive_eq(v);
      m = misr_model(m, v);
      step();
      n_checks++; if ({bus.gold_sig, bus.dut_sig} !== {m, m}) begin n_errors++; $display("FAIL misr_step%0d: got %h/%h required %h/%h", i, bus.gold_sig, bus.dut_sig, m, m); end
    end
    $display("txn misr: final sig=%h", bus.gold_sig);
    drive_eq(3'b000);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_masked();
    int   n;
    bit   seen;
    exp_t e;
    res_t got;
    run_detect("masked", 2, 0, 3'b000, 4'd5, n, seen);
    e = sb_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL %s_timeout: no result_valid within %0d cycles", e.name, n);
    end else begin
      got = sample_res();
      $display("txn %s: det=%b msk=%b spu=%b lat=%0d sel=%0d cycles=%0d", e.name, got.det, got.msk, got.spu, got.lat, got.sel, n);
      n_checks++; if (got !== e.r) begin n_errors++; $display("FAIL %s_result: got %b required %b", e.name, got, e.r); end
      n_checks++; if (n != e.cyc) begin n_errors++; $display("FAIL %s_timing: got %0d cycles required %0d", e.name, n, e.cyc); end
    end
    step();
    n_checks++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL masked_pulse: got rv=%b busy=%b required 0/0", bus.result_valid, bus.busy); end
    n_checks++; if (bus.masked !== 1'b1 || bus.det_sel !== 4'd5) begin n_errors++; $display("FAIL masked_hold: got masked=%b sel=%0d required 1/5", bus.masked, bus.det_sel); end
  endtask

  task automatic test_detect();
    int         offs[6]  = '{1, 1, 1, 5, 15, 16};
    logic [2:0] diffs[6] = '{3'b001, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
    int         n;
    bit         seen;
    exp_t       e;
    res_t       got;
    for (int c = 0; c < 6; c++) begin
      run_detect($sformatf("detect%0d", c), c % 3, offs[c], diffs[c], 4'(c + 8), n, seen);
      e = sb_q.pop_front();
      n_checks++;
      if (!seen) begin
        n_errors++; $display("FAIL %s_timeout: no result_valid within %0d cycles", e.name, n);
      end else begin
        got = sample_res();
        $display("txn %s: det=%b msk=%b spu=%b lat=%0d sel=%0d cycles=%0d", e.name, got.det, got.msk, got.spu, got.lat, got.sel, n);
        n_checks++; if (got !== e.r) begin n_errors++; $display("FAIL %s_result: got %b required %b", e.name, got, e.r); end
        n_checks++; if (n != e.cyc) begin n_errors++; $display("FAIL %s_timing: got %0d cycles required %0d", e.name, n, e.cyc); end
      end
      step();
      n_checks++; if (bus.result_valid !== 1'b0) begin n_errors++; $display("FAIL %s_pulse: result_valid got %b required 0", e.name, bus.result_valid); end
    end
  endtask

  task automatic test_spurious();
    int   n;
    bit   seen;
    exp_t e;
    res_t got;
    start_run();
    bus.gold_out = 3'b010;
    bus.dut_out  = 3'b000;
    e.name = "spurious";
    e.r    = '0;
    e.r.spu = 1'b1;
    e.cyc  = 2;
    sb_q.push_back(e);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * WINDOW) begin
      step();
      n++;
      drive_eq(3'b000);
      // An injection coinciding with the first visible mismatch must lose to it.
      bus.inj_valid = (n == 1);
      bus.inj_sel   = 4'd9;
      seen = bus.result_valid;
    end
    bus.inj_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL %s_timeout: no result_valid within %0d cycles", e.name, n);
    end else begin
      got = sample_res();
      $display("txn %s: det=%b msk=%b spu=%b lat=%0d sel=%0d cycles=%0d", e.name, got.det, got.msk, got.spu, got.lat, got.sel, n);
      n_checks++; if (got !== e.r) begin n_errors++; $display("FAIL %s_result: got %b required %b", e.name, got, e.r); end
      n_checks++; if (n != e.cyc) begin n_errors++; $display("FAIL %s_timing: got %0d cycles required %0d", e.name, n, e.cyc); end
    end
    step();
  endtask

  task automatic test_ignored();
    int   n;
    bit   seen;
    bit   dropped;
    exp_t e;
    res_t got;
    start_run();
    drive_eq(3'($urandom_range(0, 7)));
    bus.inj_valid = 1'b1;
    bus.inj_sel   = 4'd3;
    e.name  = "ignored";
    e.r     = '0;
    e.r.msk = 1'b1;
    e.r.sel = 4'd3;
    e.cyc   = WINDOW + 1;
    sb_q.push_back(e);
    n       = 0;
    seen    = 1'b0;
    dropped = 1'b0;
    while (!seen && n < 3 * WINDOW) begin
      step();
      n++;
      drive_eq(3'($urandom_range(0, 7)));
      bus.start     = (n == 4);
      bus.inj_valid = (n == 4);
      bus.inj_sel   = 4'd7;
      if (!bus.busy) dropped = 1'b1;
      seen = bus.result_valid;
    end
    bus.start     = 1'b0;
    bus.inj_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL %s_timeout: no result_valid within %0d cycles", e.name, n);
    end else begin
      got = sample_res();
      $display("txn %s: det=%b msk=%b spu=%b lat=%0d sel=%0d cycles=%0d", e.name, got.det, got.msk, got.spu, got.lat, got.sel, n);
      n_checks++; if (got !== e.r) begin n_errors++; $display("FAIL %s_result: got %b required %b", e.name, got, e.r); end
      n_checks++; if (n != e.cyc) begin n_errors++; $display("FAIL %s_timing: got %0d cycles required %0d", e.name, n, e.cyc); end
    end
    n_checks++; if (dropped !== 1'b0) begin n_errors++; $display("FAIL ignored_restart: busy dropped during run, got %b required 0", dropped); end
    step();
  endtask

  task automatic test_back_to_back();
    int   n;
    bit   seen;
    exp_t e;
    res_t got;
    run_detect("b2b", 0, 2, 3'b001, 4'd12, n, seen);
    e = sb_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL %s_timeout: no result_valid within %0d cycles", e.name, n);
    end else begin
      got = sample_res();
      $display("txn %s: det=%b msk=%b spu=%b lat=%0d sel=%0d cycles=%0d", e.name, got.det, got.msk, got.spu, got.lat, got.sel, n);
      n_checks++; if (got !== e.r) begin n_errors++; $display("FAIL %s_result: got %b required %b", e.name, got, e.r); end
      n_checks++; if (n != e.cyc) begin n_errors++; $display("FAIL %s_timing: got %0d cycles required %0d", e.name, n, e.cyc); end
    end
    bus.start = 1'b1;
    step();
    n_checks++; if (bus.busy !== 1'b0 || bus.detected !== 1'b1) begin n_errors++; $display("FAIL b2b_hold: got busy=%b det=%b required 0/1", bus.busy, bus.detected); end
    step();
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.detected !== 1'b0 || bus.det_sel !== 4'd0) begin n_errors++; $display("FAIL b2b_restart: got busy=%b det=%b sel=%0d required 1/0/0", bus.busy, bus.detected, bus.det_sel); end
    $display("txn b2b_restart: busy=%b det=%b", bus.busy, bus.detected);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_rst_midrun();
    int n;
    int rv_seen;
    start_run();
    drive_eq(3'($urandom_range(0, 7)));
    bus.inj_valid = 1'b1;
    bus.inj_sel   = 4'd6;
    n = 0;
    while (n < 6) begin
      step();
      n++;
      bus.inj_valid = 1'b0;
      drive_eq(3'($urandom_range(0, 7)));
    end
    n_checks++; if (bus.busy !== 1'b1 || bus.det_sel !== 4'd6) begin n_errors++; $display("FAIL rst_pre: got busy=%b sel=%0d required 1/6", bus.busy, bus.det_sel); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin n_errors++; $display("FAIL rst_state: got busy=%b rv=%b required 0/0", bus.busy, bus.result_valid); end
    n_checks++; if (bus.gold_sig !== 6'd0 || bus.dut_sig !== 6'd0) begin n_errors++; $display("FAIL rst_sigs: got %h/%h required 00/00", bus.gold_sig, bus.dut_sig); end
    n_checks++; if ({bus.detected, bus.masked, bus.spurious, bus.det_latency, bus.det_sel} !== 12'd0) begin n_errors++; $display("FAIL rst_results: got %b required all 0", {bus.detected, bus.masked, bus.spurious, bus.det_latency, bus.det_sel}); end
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive_eq(3'($urandom_range(0, 7)));
      step();
      if (bus.result_valid === 1'b1) rv_seen++;
    end
    n_checks++; if (rv_seen != 0) begin n_errors++; $display("FAIL rst_no_pulse: result_valid seen %0d times required 0", rv_seen); end
    n_checks++; if (bus.busy !== 1'b0 || bus.gold_sig !== 6'd0) begin n_errors++; $display("FAIL rst_idle_frozen: got busy=%b sig=%h required 0/00", bus.busy, bus.gold_sig); end
    $display("txn rst_midrun: busy=%b sigs=%h/%h", bus.busy, bus.gold_sig, bus.dut_sig);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.gold_out  = '0;
    bus.dut_out   = '0;
    bus.inj_valid = 1'b0;
    bus.inj_sel   = '0;
    test_reset();
    test_misr();
    test_masked();
    test_detect();
    test_spurious();
    test_ignored();
    test_back_to_back();
    test_rst_midrun();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
